// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared codes, state encoding and beat layout for the control sequencer
package ctrl_pkg;
  localparam logic [1:0] MODE_ALU = 2'b00, MODE_MEM = 2'b01, MODE_BR = 2'b10, MODE_NOP = 2'b11;
  localparam logic [3:0] OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010, OP_MINMAX = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100, OP_ADC = 4'b0101, OP_SBC = 4'b0110, OP_TST = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001, OP_CMP = 4'b1010, OP_ORR = 4'b1100, OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111, OP_LDR = 4'b0100;
  localparam logic [3:0] CMD_NOP = 4'b0000, CMD_MOV = 4'b0001, CMD_ADD = 4'b0010, CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100, CMD_SBC = 4'b0101, CMD_AND = 4'b0110, CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000, CMD_MVN = 4'b1001;
  localparam logic [1:0] ST_IDLE = 2'b00, ST_MM = 2'b01, ST_MUL = 2'b10;
  localparam logic [1:0] PH_NONE = 2'b00, PH_CMP = 2'b01, PH_ST = 2'b10;
  typedef struct packed {
    logic       valid;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       b;
    logic       update_flags;
    logic [1:0] phase;
  } ctrl_t;
  function automatic logic [3:0] alu_cmd(input logic [3:0] op);
    case (op)
      OP_MOV:  return CMD_MOV;
      OP_MVN:  return CMD_MVN;
      OP_ADD:  return CMD_ADD;
      OP_ADC:  return CMD_ADC;
      OP_SUB:  return CMD_SUB;
      OP_SBC:  return CMD_SBC;
      OP_AND:  return CMD_AND;
      OP_ORR:  return CMD_ORR;
      OP_EOR:  return CMD_EOR;
      OP_CMP:  return CMD_SUB;
      OP_TST:  return CMD_AND;
      default: return CMD_NOP;
    endcase
  endfunction
endpackage

// File: rtl/control_decode.sv
// control_decode: combinational single-beat decode of mode/opcode/S
module control_decode
  import ctrl_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [3:0] opcode,
  input  logic       s,
  output ctrl_t      dec,
  output logic [3:0] cmd
);
  always_comb begin
    dec = '0;
    cmd = CMD_NOP;
    dec.valid = 1'b1;
    case (mode)
      MODE_ALU: begin
        cmd = alu_cmd(opcode);
        dec.wb_en = !(opcode == OP_CMP || opcode == OP_TST);
        dec.update_flags = s;
      end
      MODE_MEM: begin
        cmd = CMD_ADD;
        dec.mem_read = opcode == OP_LDR && s;
        dec.mem_write = opcode == OP_LDR && !s;
        dec.wb_en = opcode == OP_LDR && s;
        dec.update_flags = s;
      end
      MODE_BR: dec.b = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: registered decode/issue stage expanding MINMAX and MUL into multi-beat sequences
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int               CMD_W     = 4,
  parameter int               MINMAX_EN = 1,
  parameter int               MUL_LAT   = 3,
  parameter logic [CMD_W-1:0] MUL_CMD   = CMD_W'(4'b1010)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [3:0]       opcode,
  input  logic             s,
  output logic             out_valid,
  output logic [CMD_W-1:0] exe_cmd,
  output logic             mem_read,
  output logic             mem_write,
  output logic             wb_en,
  output logic             b,
  output logic             update_flags,
  output logic [1:0]       minmax_phase,
  output logic             busy
);
  localparam int CW = $clog2(MUL_LAT + 1);
  logic [1:0] state, n_state;
  logic [CW-1:0] cnt, n_cnt;
  logic mul_s, n_mul_s;
  ctrl_t ctrl_q, n_ctrl, dec;
  logic [CMD_W-1:0] n_cmd;
  logic [3:0] dec_cmd;
  logic accept, is_mm, is_mul;
  control_decode u_dec (.mode(mode), .opcode(opcode), .s(s), .dec(dec), .cmd(dec_cmd));
  assign in_ready = !flush && !freeze && state == ST_IDLE;
  assign accept = in_valid && in_ready;
  assign is_mm = mode == MODE_ALU && opcode == OP_MINMAX;
  assign is_mul = mode == MODE_ALU && opcode == OP_MUL;
  assign busy = state != ST_IDLE;
  assign {out_valid, mem_read, mem_write, wb_en, b, update_flags, minmax_phase} = ctrl_q;
  always_comb begin
    n_ctrl = '0;
    n_cmd = '0;
    n_state = ST_IDLE;
    n_cnt = '0;
    n_mul_s = mul_s;
    if (state == ST_MM) begin
      n_ctrl.valid = 1'b1;
      n_ctrl.mem_write = 1'b1;
      n_ctrl.wb_en = 1'b1;
      n_ctrl.phase = PH_ST;
      n_cmd = CMD_W'(CMD_SUB);
    end else if (state == ST_MUL) begin
      if (cnt == CW'(1)) begin
        n_ctrl.valid = 1'b1;
        n_ctrl.wb_en = 1'b1;
        n_ctrl.update_flags = mul_s;
        n_cmd = MUL_CMD;
      end else begin
        n_ctrl = ctrl_q;
        n_cmd = exe_cmd;
        n_state = ST_MUL;
        n_cnt = cnt - CW'(1);
      end
    end else if (accept) begin
      if (is_mm) begin
        n_ctrl.valid = 1'b1;
        n_cmd = CMD_W'(CMD_SUB);
        if (MINMAX_EN != 0) begin
          n_ctrl.update_flags = 1'b1;
          n_ctrl.phase = PH_CMP;
          n_state = ST_MM;
        end else begin
          n_ctrl.mem_write = 1'b1;
          n_ctrl.wb_en = 1'b1;
          n_ctrl.update_flags = s;
          n_ctrl.phase = PH_ST;
        end
      end else if (is_mul) begin
        n_cmd = MUL_CMD;
        n_mul_s = s;
        if (MUL_LAT == 1) begin
          n_ctrl.valid = 1'b1;
          n_ctrl.wb_en = 1'b1;
          n_ctrl.update_flags = s;
        end else begin
          n_state = ST_MUL;
          n_cnt = CW'(MUL_LAT - 1);
        end
      end else begin
        n_ctrl = dec;
        n_cmd = CMD_W'(dec_cmd);
      end
    end
  end
  // flush outranks freeze so a stalled stage can still be cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      mul_s <= 1'b0;
      ctrl_q <= '0;
      exe_cmd <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      cnt <= '0;
      mul_s <= 1'b0;
      ctrl_q <= '0;
      exe_cmd <= '0;
    end else if (!freeze) begin
      state <= n_state;
      cnt <= n_cnt;
      mul_s <= n_mul_s;
      ctrl_q <= n_ctrl;
      exe_cmd <= n_cmd;
    end
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized and directed checks of control_sequencer against a beat-list model
module tb_control_sequencer;
  localparam int MUL_LAT = 3;
  logic clk = 1'b0;
  logic rst_n, freeze, flush, in_valid, s;
  logic [1:0] mode;
  logic [3:0] opcode;
  logic in_ready, out_valid, mem_read, mem_write, wb_en, b, update_flags, busy;
  logic [3:0] exe_cmd;
  logic [1:0] minmax_phase;
  logic [11:0] obs;
  int errors = 0;
  int checks = 0;
  bit [3:0] alu_tbl [16] = '{4'd6, 4'd8, 4'd4, 4'd0, 4'd2, 4'd3, 4'd5, 4'd0,
                             4'd6, 4'd0, 4'd4, 4'd0, 4'd7, 4'd1, 4'd0, 4'd9};

  control_sequencer #(.CMD_W(4), .MINMAX_EN(1), .MUL_LAT(MUL_LAT), .MUL_CMD(4'b1010)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .opcode(opcode), .s(s), .out_valid(out_valid),
    .exe_cmd(exe_cmd), .mem_read(mem_read), .mem_write(mem_write), .wb_en(wb_en), .b(b),
    .update_flags(update_flags), .minmax_phase(minmax_phase), .busy(busy)
  );

  always #5 clk = ~clk;
  assign obs = {out_valid, mem_read, mem_write, wb_en, b, update_flags, minmax_phase, exe_cmd};

  function automatic int n_beats(input logic [1:0] m, input logic [3:0] op);
    if (m == 2'd0 && op == 4'd9) return MUL_LAT;
    if (m == 2'd0 && op == 4'd3) return 2;
    return 1;
  endfunction

  // beat k of the sequence: {valid,rd,wr,wb,b,uf,phase,cmd}
  function automatic logic [11:0] ref_beat(input logic [1:0] m, input logic [3:0] op,
                                           input logic sb, input int k);
    logic ld;
    logic [11:0] r;
    ld = op == 4'd4;
    r = '0;
    case (m)
      2'd0:
        if (op == 4'd3) r = (k == 0) ? {6'b100001, 2'b01, 4'd4} : {6'b101100, 2'b10, 4'd4};
        else if (op == 4'd9) r = (k < MUL_LAT - 1) ? {8'b0, 4'd10} : {5'b10010, sb, 2'b00, 4'd10};
        else r = {3'b100, !(op == 4'd10 || op == 4'd8), 1'b0, sb, 2'b00, alu_tbl[op]};
      2'd1: r = {1'b1, ld && sb, ld && !sb, ld && sb, 1'b0, sb, 2'b00, 4'd2};
      2'd2: r = {6'b100010, 6'b0};
      default: r = {6'b100000, 6'b0};
    endcase
    return r;
  endfunction

  task automatic run_instr(input logic [1:0] m, input logic [3:0] op, input logic sb);
    int n;
    n = n_beats(m, op);
    in_valid = 1'b1; mode = m; opcode = op; s = sb;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready m=%0d op=%0h: in_ready=%b want 1", m, op, in_ready);
    end
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (obs !== ref_beat(m, op, sb, k)) begin
        errors++;
        $display("FAIL beat m=%0d op=%0h s=%0d k=%0d: got %b want %b", m, op, sb, k, obs, ref_beat(m, op, sb, k));
      end
      checks++;
      if (busy !== (k < n - 1) || in_ready !== (k == n - 1)) begin
        errors++;
        $display("FAIL busy_ready m=%0d op=%0h k=%0d: busy=%b in_ready=%b want %b %b",
                 m, op, k, busy, in_ready, k < n - 1, k == n - 1);
      end
    end
  endtask

  task automatic expect_idle_zero(input string name);
    checks++;
    if (obs !== 12'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: outputs=%b busy=%b want all zero", name, obs, busy);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1; freeze = 1'b0; flush = 1'b0; in_valid = 1'b0; mode = '0; opcode = '0; s = 1'b0;
    #1 rst_n = 1'b0;
    #1 expect_idle_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_directed;
    run_instr(2'd0, 4'd4, 1'b1);
    run_instr(2'd0, 4'd3, 1'b0);
    @(negedge clk);
    expect_idle_zero("bubble_after_minmax");
    run_instr(2'd0, 4'd9, 1'b0);
    run_instr(2'd2, 4'd5, 1'b1);
    run_instr(2'd0, 4'd10, 1'b1);
    run_instr(2'd1, 4'd4, 1'b1);
    run_instr(2'd1, 4'd4, 1'b0);
    run_instr(2'd3, 4'd7, 1'b0);
  endtask

  task automatic test_freeze;
    run_instr(2'd0, 4'd4, 1'b0);
    freeze = 1'b1; in_valid = 1'b1; mode = 2'd2;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL freeze_ready: in_ready=%b want 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (obs !== ref_beat(2'd0, 4'd4, 1'b0, 0)) begin
      errors++;
      $display("FAIL freeze_hold_beat: got %b want %b", obs, ref_beat(2'd0, 4'd4, 1'b0, 0));
    end
    freeze = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    expect_idle_zero("bubble_after_freeze");
    in_valid = 1'b1; mode = 2'd0; opcode = 4'd9; s = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    freeze = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== {8'b0, 4'd10} || busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL mul_freeze_hold%0d: obs=%b busy=%b ready=%b", i, obs, busy, in_ready);
      end
    end
    freeze = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== {8'b0, 4'd10} || busy !== 1'b1) begin
      errors++;
      $display("FAIL mul_after_freeze: obs=%b busy=%b want bubble busy", obs, busy);
    end
    @(negedge clk);
    checks++;
    if (obs !== ref_beat(2'd0, 4'd9, 1'b1, MUL_LAT - 1) || busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_final_cycle5: got %b busy=%b want %b", obs, busy, ref_beat(2'd0, 4'd9, 1'b1, MUL_LAT - 1));
    end
  endtask

  task automatic test_flush;
    in_valid = 1'b1; mode = 2'd0; opcode = 4'd3; s = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: in_ready=%b want 0", in_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    expect_idle_zero("flush_minmax");
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready_after: in_ready=%b want 1", in_ready);
    end
    @(negedge clk);
    expect_idle_zero("no_store_after_flush");
    run_instr(2'd0, 4'd10, 1'b0);
    in_valid = 1'b1; mode = 2'd0; opcode = 4'd9; s = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b1; freeze = 1'b1;
    @(negedge clk);
    flush = 1'b0; freeze = 1'b0;
    expect_idle_zero("flush_over_freeze_mul");
    @(negedge clk);
    expect_idle_zero("no_mul_final_after_flush");
  endtask

  task automatic test_async_reset;
    in_valid = 1'b1; mode = 2'd0; opcode = 4'd9; s = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mul_busy: busy=%b want 1", busy);
    end
    #2 rst_n = 1'b0;
    #1 expect_idle_zero("async_reset_mid_mul");
    #1 rst_n = 1'b1;
    @(negedge clk);
    expect_idle_zero("after_reset_release");
    run_instr(2'd0, 4'd4, 1'b0);
  endtask

  task automatic test_random;
    logic [1:0] m;
    logic [3:0] op;
    for (int i = 0; i < 80; i++) begin
      m = 2'($urandom_range(0, 3));
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) begin
        m = 2'd0;
        op = $urandom_range(0, 1) ? 4'd3 : 4'd9;
      end
      run_instr(m, op, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        expect_idle_zero("random_gap");
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_freeze();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
